// File: rtl/mult_share_ctrl_pkg.sv
// Shared widths and FSM state encoding for the shared-multiplier controller.
package mult_share_ctrl_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int ID_W   = 1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/mult_share_ctrl_multiplier.sv
// Combinational unsigned array multiplier: shifted partial products summed
// into a full-width product, so 15*15 yields 225 without truncation.
module mult_share_ctrl_multiplier
  import mult_share_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] pp [OP_W];

  genvar gi;
  generate
    for (gi = 0; gi < OP_W; gi++) begin : g_row
      assign pp[gi] = b[gi] ? (PROD_W'(a) << gi) : '0;
    end
  endgenerate

  always_comb begin
    product = '0;
    for (int i = 0; i < OP_W; i++) begin
      product = product + pp[i];
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Two-requester front end for one shared multiplier: round-robin grant in
// IDLE, one-cycle CALC, then the result is held until the consumer takes it.
module mult_share_ctrl
  import mult_share_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_a,
  input  logic [OP_W-1:0]   req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_a,
  input  logic [OP_W-1:0]   req1_b,
  output logic              req1_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_product,
  output logic [ID_W-1:0]   rsp_id,
  output logic [CNT_W-1:0]  done_count
);

  state_t            state_reg;
  logic [ID_W-1:0]   prio_reg;
  logic [OP_W-1:0]   op_a_reg;
  logic [OP_W-1:0]   op_b_reg;
  logic [ID_W-1:0]   op_id_reg;
  logic              rsp_valid_reg;
  logic [PROD_W-1:0] rsp_product_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [CNT_W-1:0]  done_count_reg;

  logic              idle;
  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic              req_hs;
  logic [PROD_W-1:0] mult_out;

  // A lone valid requester wins outright; prio only breaks ties.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = '0;
    if (req0_valid && req1_valid) begin
      grant_id = prio_reg;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign idle       = (state_reg == ST_IDLE);
  assign req0_ready = idle && grant_any && (grant_id == 1'b0);
  assign req1_ready = idle && grant_any && (grant_id == 1'b1);
  assign req_hs     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  mult_share_ctrl_multiplier u_multiplier (
    .a       (op_a_reg),
    .b       (op_b_reg),
    .product (mult_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      prio_reg        <= '0;
      op_a_reg        <= '0;
      op_b_reg        <= '0;
      op_id_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_product_reg <= '0;
      rsp_id_reg      <= '0;
      done_count_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_hs) begin
            op_a_reg  <= grant_id[0] ? req1_a : req0_a;
            op_b_reg  <= grant_id[0] ? req1_b : req0_b;
            op_id_reg <= grant_id;
            prio_reg  <= ~grant_id;
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_product_reg <= mult_out;
          rsp_id_reg      <= op_id_reg;
          rsp_valid_reg   <= 1'b1;
          state_reg       <= ST_HOLD;
        end
        ST_HOLD: begin
          // Return to IDLE only; a new grant waits a cycle, no HOLD bypass.
          if (rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
            done_count_reg <= done_count_reg + 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_reg;
  assign rsp_product = rsp_product_reg;
  assign rsp_id      = rsp_id_reg;
  assign done_count  = done_count_reg;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Randomized bench for mult_share_ctrl against a transaction-level model
// (pending-operation flags, plain a*b arithmetic, modulo counter).
module tb_mult_share_ctrl;

  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, rsp_valid;
  logic [7:0] rsp_product;
  logic [0:0] rsp_id;
  logic [CNT_W-1:0] done_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an operation is either being computed or awaiting pickup.
  bit m_calc, m_hold, m_prio;
  int m_prod, m_id, m_cnt;
  int p_prod, p_id;

  mult_share_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .done_count  (done_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_calc = 0; m_hold = 0; m_prio = 0;
    m_prod = 0; m_id = 0; m_cnt = 0;
    p_prod = 0; p_id = 0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, then advance the model.
  task automatic cycle(input bit v0, input int a0, input int b0,
                       input bit v1, input int a1, input int b1,
                       input bit rr, input bit r);
    bit idle_m, e0, e1;
    @(negedge clk);
    req0_valid = v0; req0_a = 4'(a0); req0_b = 4'(b0);
    req1_valid = v1; req1_a = 4'(a1); req1_b = 4'(b1);
    rsp_ready  = rr; rst = r;
    #1;
    idle_m = !m_calc && !m_hold;
    e0 = idle_m && v0 && (!v1 || !m_prio);
    e1 = idle_m && v1 && (!v0 || m_prio);
    check("req0_ready", 32'(req0_ready), 32'(e0));
    check("req1_ready", 32'(req1_ready), 32'(e1));
    check("rsp_valid", 32'(rsp_valid), 32'(m_hold));
    check("rsp_product", 32'(rsp_product), 32'(m_prod));
    check("rsp_id", 32'(rsp_id), 32'(m_id));
    check("done_count", 32'(done_count), 32'(m_cnt));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_hold) begin
      if (rr) begin
        m_hold = 0;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        $display("rsp id=%0d product=%0d done_count=%0d", m_id, m_prod, m_cnt);
      end
    end else if (m_calc) begin
      m_calc = 0; m_hold = 1;
      m_prod = p_prod; m_id = p_id;
    end else if (e0 || e1) begin
      p_id   = e1 ? 1 : 0;
      p_prod = e1 ? a1 * b1 : a0 * b0;
      m_prio = !e1;
      m_calc = 1;
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset values, then first cycle after release behaves as IDLE.
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 3, 5, 0, 0, 0, 1, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // Largest operands from requester 1.
    cycle(0, 0, 0, 1, 15, 15, 1, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // Both valid from reset: alternating grants every 3 cycles.
    cycle(1, 2, 7, 1, 9, 4, 1, 1);
    for (int i = 0; i < 13; i++) cycle(1, i, 7, 1, 9, 15 - i, 1, 0);

    // Consumer stalls in HOLD for 5 cycles.
    cycle(1, 11, 13, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) cycle(1, 1, 1, 1, 2, 2, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // Reset while a result is held: discarded and not counted.
    cycle(0, 0, 0, 1, 6, 6, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // Counter wrap with CNT_W=2 over several completions.
    repeat (6) begin
      cycle(1, 4, 4, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
    end

    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
